// File: rtl/dot_accum.sv
// Accumulates per-chunk tree sums into one dot-product result per vector.
// Tags ride a LAT-deep pipe so they line up with sum_in; results leave on a valid/ready port.
//
// state | meaning
// IDLE  | no vector open; next aligned beat starts one (or is a whole vector)
// ACCUM | vector open; acc/cnt/ovf_acc hold its partial result
module dot_accum #(
    parameter int W     = 16,
    parameter int ACC_W = 32,
    parameter int LAT   = 3,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [W-1:0]     sum_in,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t state_q, state_d;

    logic a_valid;
    logic a_last;

    generate
        if (LAT == 0) begin : g_nopipe
            assign a_valid = in_valid;
            assign a_last  = in_valid & in_last;
        end else begin : g_pipe
            // Each entry is {valid, last}; last is pre-qualified by valid.
            logic [1:0] tag_q [LAT];

            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
                end else begin
                    tag_q[0] <= {in_valid, in_valid & in_last};
                    for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
                end
            end

            assign a_valid = tag_q[LAT-1][1];
            assign a_last  = tag_q[LAT-1][0];
        end
    endgenerate

    logic [ACC_W-1:0] sum_ext;
    logic [ACC_W:0]   add_full;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             ovf_acc_q, ovf_acc_d;

    logic             pub;
    logic [ACC_W-1:0] pub_data;
    logic [CNT_W-1:0] pub_count;
    logic             pub_ovf;

    assign sum_ext  = ACC_W'(sum_in);
    assign add_full = {1'b0, acc_q} + {1'b0, sum_ext};
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        pub       = 1'b0;
        pub_data  = add_full[ACC_W-1:0];
        pub_count = cnt_inc;
        pub_ovf   = ovf_acc_q | add_full[ACC_W];
        case (state_q)
            IDLE: begin
                if (a_valid) begin
                    if (a_last) begin
                        pub       = 1'b1;
                        pub_data  = sum_ext;
                        pub_count = CNT_W'(1);
                        pub_ovf   = 1'b0;
                    end else begin
                        acc_d     = sum_ext;
                        cnt_d     = CNT_W'(1);
                        ovf_acc_d = 1'b0;
                        state_d   = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (a_valid) begin
                    if (a_last) begin
                        pub     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        acc_d     = add_full[ACC_W-1:0];
                        cnt_d     = cnt_inc;
                        ovf_acc_d = ovf_acc_q | add_full[ACC_W];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
        end
    end

    // A publish always wins over an accept in the same cycle, so no result is lost there.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_data  <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (pub) begin
            out_data  <= pub_data;
            out_count <= pub_count;
            out_ovf   <= pub_ovf;
            out_valid <= 1'b1;
            if (out_valid && !out_ready) overrun <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
